// File: rtl/param_ram.sv
// param_ram: parametrised single-port RAM with byte enables, init sweep and selectable read-during-write
module param_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int INIT_MODE = 0,
  parameter int RDW_MODE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              busy,
  output logic              req_drop
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB = DATA_W / 8;
  typedef enum logic {INIT, READY} state_t;
  state_t state, state_nxt;
  logic [ADDR_W:0] ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_word, merged, pattern;
  logic ready;
  assign ready = state == READY;
  assign busy = !ready;
  assign rd_word = mem[address];
  assign pattern = INIT_MODE == 1 ? '0 : DATA_W'(ptr[ADDR_W-1:0]);
  // leave INIT on the edge that writes the last entry
  always_comb begin
    state_nxt = state;
    if (state == INIT && ptr == (ADDR_W+1)'(DEPTH - 1)) state_nxt = READY;
  end
  // write word: enabled bytes from data_in, the rest from the current entry
  always_comb begin
    merged = rd_word;
    for (int k = 0; k < NB; k++) if (wr_en && wr_be[k]) merged[8*k +: 8] = data_in[8*k +: 8];
  end
  // state register and sweep pointer
  always_ff @(posedge clk) begin
    state <= reset ? INIT : state_nxt;
    ptr <= reset ? '0 : (ready ? ptr : ptr + (ADDR_W+1)'(1));
  end
  // storage: sweep pattern while initialising, byte-merged writes once ready
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (!ready) mem[ptr[ADDR_W-1:0]] <= pattern;
      else if (wr_en) mem[address] <= merged;
    end
  end
  // registered read port and dropped-request flag
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out <= '0;
      rd_valid <= 1'b0;
      req_drop <= 1'b0;
    end else begin
      rd_valid <= ready && rd_en;
      req_drop <= !ready && (rd_en || wr_en);
      if (ready && rd_en) data_out <= RDW_MODE == 1 ? merged : rd_word;
    end
  end
endmodule

// File: tb/tb_param_ram.sv
// tb_param_ram: directed checks of init sweep, byte-enable writes, read-during-write and reset restart
module tb_param_ram;
  logic clk = 0, reset = 1;
  logic wr_en = 0, rd_en = 0;
  logic [1:0] wr_be = 0;
  logic [3:0] address = 0;
  logic [15:0] data_in = 0;
  logic [15:0] data_out, data_out3;
  logic rd_valid, busy, req_drop, rd_valid3, busy3, req_drop3;
  logic wr_en2 = 0, rd_en2 = 0;
  logic [3:0] wr_be2 = 0;
  logic [5:0] address2 = 0;
  logic [31:0] data_in2 = 0, data_out2;
  logic rd_valid2, busy2, req_drop2;
  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  param_ram #(.DATA_W(16), .ADDR_W(4), .INIT_MODE(0), .RDW_MODE(0)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_be(wr_be), .rd_en(rd_en), .address(address),
    .data_in(data_in), .data_out(data_out), .rd_valid(rd_valid), .busy(busy), .req_drop(req_drop));

  param_ram #(.DATA_W(32), .ADDR_W(6), .INIT_MODE(0), .RDW_MODE(1)) dut2 (
    .clk(clk), .reset(reset), .wr_en(wr_en2), .wr_be(wr_be2), .rd_en(rd_en2), .address(address2),
    .data_in(data_in2), .data_out(data_out2), .rd_valid(rd_valid2), .busy(busy2), .req_drop(req_drop2));

  param_ram #(.DATA_W(16), .ADDR_W(2), .INIT_MODE(1), .RDW_MODE(0)) dut3 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_be(wr_be), .rd_en(rd_en), .address(address[1:0]),
    .data_in(data_in), .data_out(data_out3), .rd_valid(rd_valid3), .busy(busy3), .req_drop(req_drop3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd16(input logic [3:0] a, input logic [15:0] exp, input string name);
    address = a; rd_en = 1; tick(); rd_en = 0;
    vectors++; if (rd_valid !== 1'b1) begin miscompares++; $display("FAIL %s rd_valid got %b want 1", name, rd_valid); end
    vectors++; if (data_out !== exp) begin miscompares++; $display("FAIL %s data_out got %h want %h", name, data_out, exp); end
  endtask

  task automatic rd32(input logic [5:0] a, input logic [31:0] exp, input string name);
    address2 = a; rd_en2 = 1; tick(); rd_en2 = 0;
    vectors++; if (rd_valid2 !== 1'b1) begin miscompares++; $display("FAIL %s rd_valid got %b want 1", name, rd_valid2); end
    vectors++; if (data_out2 !== exp) begin miscompares++; $display("FAIL %s data_out got %h want %h", name, data_out2, exp); end
  endtask

  task automatic test_reset();
    reset = 1; tick(); tick();
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL reset_busy got %b want 1", busy); end
    vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
    vectors++; if (req_drop !== 1'b0) begin miscompares++; $display("FAIL reset_req_drop got %b want 0", req_drop); end
    vectors++; if (data_out !== 16'h0) begin miscompares++; $display("FAIL reset_data_out got %h want 0000", data_out); end
    vectors++; if (busy3 !== 1'b1) begin miscompares++; $display("FAIL reset_busy3 got %b want 1", busy3); end
    reset = 0; rd_en = 1; address = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      vectors++; if (busy !== (i < 16)) begin miscompares++; $display("FAIL sweep_busy edge %0d got %b want %b", i, busy, i < 16); end
      vectors++; if (req_drop !== 1'b1) begin miscompares++; $display("FAIL sweep_req_drop edge %0d got %b want 1", i, req_drop); end
      vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL sweep_rd_valid edge %0d got %b want 0", i, rd_valid); end
      vectors++; if (req_drop3 !== (i <= 4)) begin miscompares++; $display("FAIL sweep3_req_drop edge %0d got %b want %b", i, req_drop3, i <= 4); end
      vectors++; if (rd_valid3 !== (i > 4)) begin miscompares++; $display("FAIL sweep3_rd_valid edge %0d got %b want %b", i, rd_valid3, i > 4); end
    end
    rd_en = 0;
  endtask

  task automatic test_init_pattern();
    for (int a = 0; a < 16; a++) begin
      rd16(4'(a), 16'(a), "init_read");
      vectors++; if (data_out3 !== 16'h0) begin miscompares++; $display("FAIL init_zero addr %0d got %h want 0000", a % 4, data_out3); end
    end
    tick();
    vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL idle_rd_valid got %b want 0", rd_valid); end
    vectors++; if (data_out !== 16'h000F) begin miscompares++; $display("FAIL idle_hold got %h want 000f", data_out); end
  endtask

  task automatic test_byte_enable();
    address = 5; data_in = 16'hABCD; wr_be = 2'b01; wr_en = 1; tick(); wr_en = 0;
    rd16(5, 16'h00CD, "be_low");
    data_in = 16'h12FF; wr_be = 2'b10; wr_en = 1; tick(); wr_en = 0;
    rd16(5, 16'h12CD, "be_high");
    data_in = 16'h7777; wr_be = 2'b00; wr_en = 1; tick(); wr_en = 0;
    rd16(5, 16'h12CD, "be_none");
  endtask

  task automatic test_read_during_write();
    address = 3; data_in = 16'hBEEF; wr_be = 2'b11; wr_en = 1; rd_en = 1; tick(); wr_en = 0; rd_en = 0;
    vectors++; if (data_out !== 16'h0003) begin miscompares++; $display("FAIL rdw_old got %h want 0003", data_out); end
    rd16(3, 16'hBEEF, "rdw_after");
  endtask

  task automatic test_reset_restart();
    address = 7; data_in = 16'h5555; wr_be = 2'b11; wr_en = 1; tick(); wr_en = 0;
    rd16(7, 16'h5555, "pre_reset");
    reset = 1; tick(); tick(); reset = 0;
    repeat (6) tick();
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL midsweep_busy got %b want 1", busy); end
    reset = 1; tick(); reset = 0;
    vectors++; if (data_out !== 16'h0) begin miscompares++; $display("FAIL rerst_data_out got %h want 0000", data_out); end
    repeat (15) tick();
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL restart_busy15 got %b want 1", busy); end
    tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL restart_busy16 got %b want 0", busy); end
    rd16(7, 16'h0007, "restart_addr7");
    rd16(0, 16'h0000, "restart_addr0");
  endtask

  task automatic test_wide();
    int n = 0;
    reset = 1; tick(); reset = 0;
    while (busy2 && n < 200) begin tick(); n++; end
    vectors++; if (n !== 64) begin miscompares++; $display("FAIL wide_busy_edges got %0d want 64", n); end
    rd32(63, 32'h0000003F, "wide_addr63");
    rd32(0, 32'h00000000, "wide_addr0");
    address2 = 10; data_in2 = 32'h11223344; wr_be2 = 4'b0101; wr_en2 = 1; rd_en2 = 1; tick(); wr_en2 = 0; rd_en2 = 0;
    vectors++; if (data_out2 !== 32'h00220044) begin miscompares++; $display("FAIL wide_rdw_new got %h want 00220044", data_out2); end
    data_in2 = 32'hAABBCCDD; wr_be2 = 4'b1000; wr_en2 = 1; rd_en2 = 1; tick(); wr_en2 = 0; rd_en2 = 0;
    vectors++; if (data_out2 !== 32'hAA220044) begin miscompares++; $display("FAIL wide_rdw_byte3 got %h want aa220044", data_out2); end
    rd32(10, 32'hAA220044, "wide_merge");
    rd32(11, 32'h0000000B, "wide_neighbour");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_init_pattern();
    test_byte_enable();
    test_read_during_write();
    test_reset_restart();
    test_wide();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/param_ram.md
Name: param_ram

Overview:
- Parametrised single-port synchronous RAM; next generation of the team's 16x16 scratch RAM.
- Adds configurable width and depth, per-byte write enables, a registered read with a valid flag, and a selectable read-during-write mode.
- Adds a hardware init sweep after reset that fills memory with a known pattern.
- Used as a general scratch/register-file store by the datapath blocks.

Parameters:
DATA_W, 16, data width in bits; must be a multiple of 8
ADDR_W, 4, address width; DEPTH = 2**ADDR_W
INIT_MODE, 0, init-sweep pattern: 0 = each word loaded with its own index (zero-extended or truncated to DATA_W); 1 = all zeros
RDW_MODE, 0, same-address read during write: 0 = read-first (old data); 1 = write-first (new merged data)

Ports:
clk  input  1  clock, all logic on posedge
reset  input  1  synchronous, active-high reset
wr_en  input  1  write request
wr_be  input  DATA_W/8  byte enables; bit k covers data_in[8k+7:8k]
rd_en  input  1  read request
address  input  ADDR_W  shared read/write address
data_in  input  DATA_W  write data
data_out  output  DATA_W  registered read data
rd_valid  output  1  one-cycle pulse; data_out updated this cycle
busy  output  1  init sweep in progress; requests not accepted
req_drop  output  1  one-cycle pulse; a request arrived while busy and was discarded

Behaviour:
- Single clock; reset is synchronous and active-high. All state changes on posedge clk.
- Reset values, on the cycle after any edge with reset=1:
  - data_out=0, rd_valid=0, req_drop=0, busy=1
  - state=INIT, sweep pointer=0
  - No memory writes occur while reset=1.
- State INIT, reset=0:
  - Each edge writes the pattern word to mem[ptr], then ptr increments.
  - The edge that writes DEPTH-1 moves to READY and clears busy.
  - busy is therefore high for exactly DEPTH edges after reset deasserts.
- State INIT, requests:
  - wr_en or rd_en asserted is discarded: no memory change, rd_valid=0, data_out holds.
  - req_drop=1 the following cycle.
- Reset asserted mid-sweep: the sweep restarts from ptr=0 after reset deasserts; partially written entries are simply rewritten.
- State READY, write (wr_en=1):
  - Each byte k with wr_be[k]=1 takes data_in[8k+7:8k]; the other bytes keep their old value.
  - wr_be all-zero: no change.
- State READY, read (rd_en=1):
  - data_out <= mem[address] at the edge, 1-cycle latency.
  - rd_valid=1 for that one cycle.
  - With rd_en=0, data_out holds its last value and rd_valid=0.
- Simultaneous rd_en and wr_en (same address, since the address is shared):
  - RDW_MODE=0: data_out = pre-write word.
  - RDW_MODE=1: data_out = post-write merged word; bytes not enabled show the old content.
  - The memory update is identical in both modes.
- Address arithmetic:
  - address covers exactly DEPTH entries, so there is no out-of-range case.
  - Sweep ptr is ADDR_W+1 bits wide so termination is detected without wrap.
- No state exists beyond INIT and READY. READY leaves only on reset.
- Memory contents are not cleared by reset except through the sweep.

Test Plan:
1. Reset 2 cycles, release, hold rd_en=1 from release -> busy=1 for 16 edges; req_drop=1 each of those cycles; rd_valid stays 0; busy=0 on the 16th edge.
2. After init, INIT_MODE=0: read addresses 0..15 -> data_out = 0x0000..0x000F, each 1 cycle after rd_en, with rd_valid pulses. INIT_MODE=1: all reads return 0x0000.
3. Write addr 5, data_in=0xABCD, wr_be=2'b01, then read 5 -> 0x00CD (INIT_MODE=0). Then wr_be=2'b10 with 0x12FF, read -> 0x12CD. wr_be=2'b00 -> unchanged.
4. Addr 3 holding 0x0003: write 0xBEEF with wr_be=2'b11 and rd_en=1 in the same cycle -> data_out=0x0003 (RDW_MODE=0) or 0xBEEF (RDW_MODE=1); next read returns 0xBEEF in both modes.
5. Write addr 7 = 0x5555, then assert reset for 1 cycle at sweep ptr=6 during a second reset sequence -> sweep restarts; after 16 further edges, addr 7 reads 0x0007 and addr 0 reads 0x0000.
6. Parameter sweep DATA_W=32, ADDR_W=6 -> busy high 64 edges; addr 63 reads 0x0000003F; 4-bit wr_be merges individual bytes correctly.
